// File: rtl/parity_tx_if.sv
// Bundle between the requesters and parity_tx_scheduler.
//   master : requester side. Drives req/data_in and observes grant and serial outputs.
//   slave  : scheduler side. Samples req/data_in and drives grant and serial outputs.
// Signals:
//   req[NUM_REQ]          per-requester request level
//   data_in[NUM_REQ*W]    requester words, requester i at [i*WORD_W +: WORD_W]
//   gnt[NUM_REQ]          one-hot grant pulse
//   src_id                owner of the current frame
//   busy, wr_en, data_out, par_bit   frame status and serial lane
interface parity_tx_if #(
    parameter int NUM_REQ = 4,
    parameter int WORD_W  = 8
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*WORD_W-1:0] data_in;
    logic [NUM_REQ-1:0]        gnt;
    logic [ID_W-1:0]           src_id;
    logic                      busy;
    logic                      wr_en;
    logic                      data_out;
    logic                      par_bit;

    modport master (
        output req, data_in,
        input  gnt, src_id, busy, wr_en, data_out, par_bit
    );

    modport slave (
        input  req, data_in,
        output gnt, src_id, busy, wr_en, data_out, par_bit
    );
endinterface

// File: rtl/parity_tx_scheduler.sv
// Round-robin scheduler sharing one serial parity-framed transmit lane between
// NUM_REQ requesters. A frame is: LOAD (grant pulse), WORD_W data bits MSB-first,
// one parity bit, then GAP_CYCLES idle cycles, then at least one IDLE cycle in
// which the next arbitration takes place.
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    parity_tx_if.slave: req/data_in in; gnt, src_id, busy, wr_en,
//          data_out, par_bit out (all registered)
module parity_tx_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int WORD_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int GAP_CYCLES = 1
) (
    input logic       clk,
    input logic       rst_n,
    parity_tx_if.slave bus
);
    localparam int   ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int   CNT_W = $clog2(WORD_W + 1);
    // gap_cnt holds GAP_CYCLES-1 down to 0
    localparam int   GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic ODD   = (ODD_PARITY != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;

    logic [2:0]                        state;
    logic [ID_W-1:0]                   last;
    logic [ID_W-1:0]                   win_idx;
    logic                              win_vld;
    logic [WORD_W-1:0]                 word;
    logic [CNT_W-1:0]                  bit_cnt;
    logic [GAP_W-1:0]                  gap_cnt;
    logic                              acc;
    logic [NUM_REQ-1:0][WORD_W-1:0]    data_arr;

    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    src_q;
    logic               busy_q;
    logic               wr_q;
    logic               dout_q;
    logic               par_q;

    assign data_arr     = bus.data_in;
    assign bus.gnt      = gnt_q;
    assign bus.src_id   = src_q;
    assign bus.busy     = busy_q;
    assign bus.wr_en    = wr_q;
    assign bus.data_out = dout_q;
    assign bus.par_bit  = par_q;

    // Cyclic search starting one past the last winner.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            last    <= ID_W'(NUM_REQ - 1);
            word    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            acc     <= 1'b0;
            gnt_q   <= '0;
            src_q   <= '0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        word   <= data_arr[win_idx];
                        last   <= win_idx;
                        src_q  <= win_idx;
                        gnt_q  <= NUM_REQ'(1) << win_idx;
                        busy_q <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Accumulator restarts here: seeding it with the first bit
                    // equals clearing it and XORing that bit in.
                    wr_q    <= 1'b1;
                    dout_q  <= word[WORD_W-1];
                    acc     <= word[WORD_W-1];
                    word    <= word << 1;
                    bit_cnt <= CNT_W'(WORD_W - 1);
                    state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_cnt != '0) begin
                        dout_q  <= word[WORD_W-1];
                        acc     <= acc ^ word[WORD_W-1];
                        word    <= word << 1;
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        dout_q <= acc ^ ODD;
                        par_q  <= 1'b1;
                        state  <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    wr_q   <= 1'b0;
                    dout_q <= 1'b0;
                    par_q  <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parity_tx_scheduler.sv
// Bench for parity_tx_scheduler. Two instances share the same stimulus:
// dut_a (even parity, GAP_CYCLES=1) and dut_b (odd parity, GAP_CYCLES=0).
// Each is compared every cycle against a frame-timeline model that tracks
// the offset within the current frame, plus directed constant checks.
module tb_parity_tx_scheduler;
    localparam int N = 4;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    parity_tx_if #(.NUM_REQ(N), .WORD_W(W)) ifa ();
    parity_tx_if #(.NUM_REQ(N), .WORD_W(W)) ifb ();

    assign ifa.req = req;
    assign ifa.data_in = data;
    assign ifb.req = req;
    assign ifb.data_in = data;

    parity_tx_scheduler #(.NUM_REQ(N), .WORD_W(W), .ODD_PARITY(0), .GAP_CYCLES(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    parity_tx_scheduler #(.NUM_REQ(N), .WORD_W(W), .ODD_PARITY(1), .GAP_CYCLES(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    // model state per instance
    bit         m_act[2];
    int         m_t[2];
    logic [7:0] m_w[2];
    int         m_ptr[2];
    int         m_src[2];
    int         m_win[2];
    int         m_gap[2] = '{1, 0};
    logic       m_odd[2] = '{1'b0, 1'b1};

    int ga_cyc[$], ga_id[$], gb_cyc[$], gb_id[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [3:0] g);
        int r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_act[m] = 0; m_t[m] = 0; m_w[m] = '0;
            m_ptr[m] = N - 1; m_src[m] = 0; m_win[m] = 0;
        end
    endtask

    // Frame of length W+3+gap edges: offset 0 grant, 1..W data, W+1 parity,
    // then gap cycles, then one idle cycle; the next edge arbitrates again.
    task automatic model_edge(input int m);
        bit found;
        int i;
        if (m_act[m]) begin
            m_t[m]++;
            if (m_t[m] == W + 3 + m_gap[m]) m_act[m] = 0;
        end
        if (!m_act[m] && req != 4'b0) begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
                i = (m_ptr[m] + k) % N;
                if (!found && req[i]) begin found = 1; m_win[m] = i; end
            end
            m_act[m] = 1; m_t[m] = 0;
            m_w[m]   = data[m_win[m]*8 +: 8];
            m_ptr[m] = m_win[m];
            m_src[m] = m_win[m];
        end
    endtask

    task automatic check_dut(input int m);
        logic [3:0] eg, og;
        logic       eb, ew, ed, ep, ob, ow, od, op;
        int         os, t;
        string      p;
        eg = '0; eb = 0; ew = 0; ed = 0; ep = 0; t = m_t[m];
        if (m_act[m]) begin
            if (t == 0) begin
                eg = 4'(1 << m_win[m]); eb = 1;
            end else if (t <= W) begin
                eb = 1; ew = 1; ed = m_w[m][W-t];
            end else if (t == W + 1) begin
                eb = 1; ew = 1; ep = 1; ed = (^m_w[m]) ^ m_odd[m];
            end else if (t <= W + 1 + m_gap[m]) begin
                eb = 1;
            end
        end
        if (m == 0) begin
            p = "a"; og = ifa.gnt; os = int'(ifa.src_id); ob = ifa.busy;
            ow = ifa.wr_en; od = ifa.data_out; op = ifa.par_bit;
        end else begin
            p = "b"; og = ifb.gnt; os = int'(ifb.src_id); ob = ifb.busy;
            ow = ifb.wr_en; od = ifb.data_out; op = ifb.par_bit;
        end
        chk({p, "_gnt"},   32'(og), 32'(eg));
        chk({p, "_src"},   32'(os), 32'(m_src[m]));
        chk({p, "_busy"},  32'(ob), 32'(eb));
        chk({p, "_wr_en"}, 32'(ow), 32'(ew));
        chk({p, "_dout"},  32'(od), 32'(ed));
        chk({p, "_par"},   32'(op), 32'(ep));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check_dut(0);
        check_dut(1);
        if (ifa.gnt != 4'b0) begin ga_cyc.push_back(cyc); ga_id.push_back(idx_of(ifa.gnt)); end
        if (ifb.gnt != 4'b0) begin gb_cyc.push_back(cyc); gb_id.push_back(idx_of(ifb.gnt)); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_log();
        ga_cyc.delete(); ga_id.delete(); gb_cyc.delete(); gb_id.delete();
    endtask

    // single frame from requester idx, checks parity bit of both instances
    task automatic send_one(input int idx, input logic [7:0] w, input logic pa, input logic pb);
        data[idx*8 +: 8] = w;
        req = 4'(1 << idx);
        tick();
        req = 4'b0;
        repeat (W) tick();
        tick();
        chk("par_flag_a", 32'(ifa.par_bit), 32'd1);
        chk("par_val_a", 32'(ifa.data_out), 32'(pa));
        chk("par_val_b", 32'(ifb.data_out), 32'(pb));
        repeat (2) tick();
    endtask

    initial begin
        logic [7:0] pat, x, got;
        int         n2;
        model_reset();

        // reset state and plain frame from requester 1
        do_reset();
        pat = 8'hA5;
        data[15:8] = pat;
        req = 4'b0010;
        tick();
        chk("t1_gnt", 32'(ifa.gnt), 32'h2);
        chk("t1_src", 32'(ifa.src_id), 32'd1);
        req = 4'b0;
        for (int i = 0; i < W; i++) begin
            tick();
            chk("t1_wr", 32'(ifa.wr_en), 32'd1);
            chk("t1_bit", 32'(ifa.data_out), 32'(pat[7-i]));
        end
        tick();
        chk("t1_par_a", 32'(ifa.data_out), 32'd0);
        chk("t1_par_b", 32'(ifb.data_out), 32'd1);
        chk("t1_pflag", 32'(ifa.par_bit), 32'd1);
        repeat (3) tick();

        // parity values for boundary words
        send_one(0, 8'hFF, 1'b0, 1'b1);
        send_one(2, 8'h01, 1'b1, 1'b0);
        send_one(3, 8'h00, 1'b0, 1'b1);

        // all requesters held from reset release
        do_reset();
        data = $urandom;
        req = 4'hF;
        clear_log();
        repeat (62) tick();
        req = 4'b0;
        chk("t2_a_count", 32'(ga_id.size() >= 5), 32'd1);
        chk("t2_b_count", 32'(gb_id.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < ga_id.size()) chk("t2_a_order", 32'(ga_id[i]), 32'(i % 4));
            if (i < gb_id.size()) chk("t2_b_order", 32'(gb_id[i]), 32'(i % 4));
            if (i > 0 && i < ga_cyc.size()) chk("t2_a_period", 32'(ga_cyc[i] - ga_cyc[i-1]), 32'd12);
            if (i > 0 && i < gb_cyc.size()) chk("t2_b_period", 32'(gb_cyc[i] - gb_cyc[i-1]), 32'd11);
        end
        repeat (14) tick();

        // asynchronous reset after three data bits
        do_reset();
        data = $urandom;
        req = 4'b0001;
        tick();
        req = 4'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t4_wr", 32'(ifa.wr_en), 32'd0);
        chk("t4_dout", 32'(ifa.data_out), 32'd0);
        chk("t4_par", 32'(ifa.par_bit), 32'd0);
        chk("t4_busy", 32'(ifa.busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1001;
        tick();
        chk("t4_gnt_a", 32'(ifa.gnt), 32'h1);
        chk("t4_gnt_b", 32'(ifb.gnt), 32'h1);
        req = 4'b0;
        repeat (W + 4) tick();

        // short pulse on req[2] during a frame is never served
        clear_log();
        data = $urandom;
        req = 4'b0001;
        tick();
        req = 4'b0;
        repeat (3) tick();
        req = 4'b0100;
        tick();
        req = 4'b0;
        repeat (W + 8) tick();
        n2 = 0;
        foreach (ga_id[i]) if (ga_id[i] == 2) n2++;
        chk("t5_no_gnt2", 32'(n2), 32'd0);
        chk("t5_one_gnt", 32'(ga_id.size()), 32'd1);
        chk("t5_idle", 32'(ifa.busy), 32'd0);

        // data_in changes after the grant do not affect the frame
        x = 8'($urandom);
        data[15:8] = x;
        req = 4'b0010;
        tick();
        req = 4'b0;
        data[15:8] = ~x;
        got = '0;
        for (int i = 0; i < W; i++) begin
            tick();
            got = {got[6:0], ifa.data_out};
        end
        chk("t6_word", 32'(got), 32'(x));
        repeat (4) tick();

        // randomized traffic, both instances against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            if ($urandom_range(0, 1) == 0) data = $urandom;
            tick();
        end
        req = 4'b0;
        repeat (W + 6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
